// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the nibble-serial adder family.
package nibble_add_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned nibbles(input int unsigned width);
    return width / NIB;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// Combinational 4-bit ripple-carry slice shared by every nibble of the serial add.
module nibble_serial_adder_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           c_in,
  output logic [NIB-1:0] s,
  output logic           c_out
);

  logic [NIB:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < int'(NIB); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_out = c[NIB];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit slice, WIDTH/4 add cycles, registered result and flags.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NIB   = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             Overflow
);

  import nibble_add_pkg::*;

  localparam int unsigned NIBS  = nibbles(WIDTH);
  localparam int unsigned CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned SH_W  = (WIDTH > NIB) ? WIDTH - NIB : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBS - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SH_W-1:0]  s_sh;
  logic [CNT_W-1:0] cnt;
  logic             cy, a_msb, b_msb;

  logic [NIB-1:0]   slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] s_next;

  nibble_serial_adder_slice u_slice (
    .a     (a_sh[NIB-1:0]),
    .b     (b_sh[NIB-1:0]),
    .c_in  (cy),
    .s     (slice_s),
    .c_out (slice_co)
  );

  // Partial sum grows from the top; after the last nibble it is the full result.
  if (WIDTH > NIB) begin : g_wide
    assign s_next = {slice_s, s_sh};
  end else begin : g_single
    assign s_next = slice_s;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      Ready <= 1'b1;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_next;
      Ready <= (state_next == IDLE);
      Busy  <= (state_next == ADD);
      Done  <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Run) state_next = ADD;
      ADD:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand/partial-sum shifting and result publication on the last nibble.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      Sum      <= '0;
      C_out    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            a_sh  <= A_in;
            b_sh  <= B_in;
            cy    <= C_in;
            cnt   <= '0;
            a_msb <= A_in[WIDTH-1];
            b_msb <= B_in[WIDTH-1];
          end
        end
        ADD: begin
          a_sh <= a_sh >> NIB;
          b_sh <= b_sh >> NIB;
          s_sh <= s_next[WIDTH-1 -: SH_W];
          cy   <= slice_co;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            Sum      <= s_next;
            C_out    <= slice_co;
            Overflow <= (a_msb == b_msb) && (slice_s[NIB-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  logic        Clk = 1'b0;
  logic        Reset_n, Run, C_in;
  logic [15:0] A_in, B_in;
  logic        Ready, Busy, Done, C_out, Overflow;
  logic [15:0] Sum;

  nibble_serial_adder #(.WIDTH(16), .NIB(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .A_in(A_in), .B_in(B_in), .C_in(C_in),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Sum(Sum), .C_out(C_out), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always @(negedge Clk) if (Done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t e;
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + 17'(cin);
    e.sum  = t[15:0];
    e.cout = t[16];
    e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    chk({tag, "_pending"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"},  32'(Sum),      32'(e.sum));
      chk({tag, "_cout"}, 32'(C_out),    32'(e.cout));
      chk({tag, "_ovf"},  32'(Overflow), 32'(e.ovf));
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
    chk({tag, "_ready"}, 32'(Ready), 32'd1);
    A_in = a; B_in = b; C_in = cin; Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    sb.push_back(model(a, b, cin));
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (Done !== 1'b1 && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (Done !== 1'b1) chk({tag, "_timeout"}, 32'(Done), 32'd1);
    else compare_pop(tag);
  endtask

  logic [15:0] ha[4], hb[4];
  logic        hc[4];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int d0, idx, results, cyc, last_acc;

    Reset_n = 1'b0; Run = 1'b0; A_in = '0; B_in = '0; C_in = 1'b0;
    #12;
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(C_out), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_ready", 32'(Ready), 32'd1);

    // Basic add with latency check
    start_op("t1", 16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_busy", 32'(Busy), 32'd1);
      chk("t1_nodone", 32'(Done), 32'd0);
      @(negedge Clk);
    end
    chk("t1_done", 32'(Done), 32'd1);
    chk("t1_sum_const", 32'(Sum), 32'h5555);
    wait_done("t1");
    @(negedge Clk);
    chk("t1_ready_after", 32'(Ready), 32'd1);
    chk("t1_done_low", 32'(Done), 32'd0);

    start_op("t2", 16'hFFFF, 16'h0001, 1'b0); wait_done("t2"); @(negedge Clk);
    start_op("t3", 16'h00FF, 16'h0000, 1'b1); wait_done("t3"); @(negedge Clk);
    start_op("t4", 16'h7FFF, 16'h0001, 1'b0); wait_done("t4"); @(negedge Clk);
    start_op("t5", 16'h8000, 16'h8000, 1'b0); wait_done("t5");
    chk("t5_ovf_const", 32'(Overflow), 32'd1);
    @(negedge Clk);

    // Run during ADD and DONE must be ignored
    d0 = done_cnt;
    start_op("ign", 16'h0001, 16'h0001, 1'b0);
    A_in = 16'hAAAA; B_in = 16'h5555; C_in = 1'b1; Run = 1'b1;
    @(negedge Clk); Run = 1'b0;
    wait_done("ign");
    Run = 1'b1;
    @(negedge Clk); Run = 1'b0;
    chk("ign_ready", 32'(Ready), 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    chk("ign_busy", 32'(Busy), 32'd0);
    chk("ign_sum", 32'(Sum), 32'h0002);
    chk("ign_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Run held high: back-to-back operations
    ha[0] = 16'h1111; hb[0] = 16'h2222; hc[0] = 1'b0;
    ha[1] = 16'h9999; hb[1] = 16'h9999; hc[1] = 1'b1;
    ha[2] = 16'h0FFF; hb[2] = 16'h0001; hc[2] = 1'b0;
    ha[3] = 16'h4000; hb[3] = 16'h4000; hc[3] = 1'b0;
    idx = 0; results = 0; cyc = 0; last_acc = -1;
    A_in = ha[0]; B_in = hb[0]; C_in = hc[0]; Run = 1'b1;
    while (results < 4 && cyc < 60) begin
      if (Done === 1'b1) begin
        compare_pop("held");
        results++;
        idx++;
        if (idx < 4) begin
          A_in = ha[idx]; B_in = hb[idx]; C_in = hc[idx];
        end else begin
          Run = 1'b0;
        end
      end
      if (Ready === 1'b1 && Run === 1'b1) begin
        sb.push_back(model(A_in, B_in, C_in));
        if (last_acc >= 0) chk("held_period", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
      end
      @(negedge Clk);
      cyc++;
    end
    Run = 1'b0;
    chk("held_count", 32'(results), 32'd4);
    @(negedge Clk);

    // Reset in the third ADD cycle aborts the operation
    start_op("rst_mid", 16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_cout", 32'(C_out), 32'd0);
    chk("abort_ovf", 32'(Overflow), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    sb.delete();
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);
    chk("abort_ready", 32'(Ready), 32'd1);
    start_op("post", 16'h0F0F, 16'h0101, 1'b0);
    wait_done("post");
    chk("post_sum_const", 32'(Sum), 32'h1010);
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential, nibble-serial adder datapath for the lab adder family. Registers two WIDTH-bit operands, adds them one 4-bit slice per clock through a single 4-bit ripple-carry slice, and presents a registered sum, carry-out and signed overflow.
- Sits directly upstream of the 4-bit ripple slice: it owns the operand and sum shift registers and the carry flop, and it consumes the slice's S/c_out every cycle.
- Trades 4x-fewer adder cells for WIDTH/4 cycles of latency.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 4.
- NIB, 4, slice width; fixed at 4; present only for readability.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset; one clock domain only.
- Run  input  1  start request; accepted only when Ready=1.
- A_in  input  WIDTH  operand A; sampled on the accept edge only.
- B_in  input  WIDTH  operand B; sampled on the accept edge only.
- C_in  input  1  carry-in; sampled on the accept edge only.
- Ready  output  1  high in IDLE.
- Busy  output  1  high in ADD.
- Done  output  1  one-cycle pulse; high while the new Sum is first valid.
- Sum  output  WIDTH  registered result; holds its value until the next completion.
- C_out  output  1  registered carry out of the MSB.
- Overflow  output  1  registered two's-complement overflow.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=IDLE; Sum=0, C_out=0, Overflow=0, Done=0.
  - Ready=1 once reset is released; all shift registers, the carry flop and the count are 0.
  - Reset mid-ADD aborts the operation; no partial Sum is ever published.
- FSM states: IDLE, ADD, DONE.
  - IDLE -> ADD on an edge where Run=1.
  - ADD -> DONE on the edge that processes nibble WIDTH/4-1.
  - DONE -> IDLE unconditionally on the next edge.
- Accept edge (IDLE & Run):
  - a_sh<=A_in, b_sh<=B_in, cy<=C_in, cnt<=0.
  - Latch a_msb=A_in[WIDTH-1] and b_msb=B_in[WIDTH-1].
- Each ADD edge:
  - Slice inputs are a_sh[3:0], b_sh[3:0] and cy.
  - s_sh <= {slice.S, s_sh[WIDTH-1:4]}, so nibble k ends up in bits [4k+3:4k].
  - a_sh and b_sh shift right by 4; cy<=slice.c_out; cnt<=cnt+1.
- Last ADD edge (cnt==WIDTH/4-1):
  - Sum<=final shifted value; C_out<=slice.c_out; Done<=1.
  - Overflow<=(a_msb==b_msb) && (S[WIDTH-1]!=a_msb).
  - Sum, C_out and Overflow change only on this edge.
- Latency: accept edge at T. Done=1 and Sum valid during the cycle after edge T+WIDTH/4, i.e. edge T+4 for WIDTH=16. Ready=1 again after edge T+WIDTH/4+1.
- Throughput: one operation every WIDTH/4+2 cycles with Run held high.
- Run while Busy or during DONE is ignored; operands are not re-sampled. Changes on A_in, B_in or C_in after accept have no effect.
- Arithmetic is unsigned modulo 2^WIDTH, with C_out as bit WIDTH. Overflow is the signed interpretation of the same add, including C_in.
- cnt width is $clog2(WIDTH/4), minimum 1. When WIDTH=4 there is a single ADD cycle.
- Ready, Busy and Done decode directly from state, with no combinational path from Run.

Decomposition:
- Shared package nibble_add_pkg:
  - state enum {IDLE, ADD, DONE};
  - localparam NIB=4;
  - helper function nibbles(WIDTH)=WIDTH/4.
- One natural sub-module: the combinational 4-bit ripple-carry slice (A, B, c_in -> S, c_out), instantiated once.
- FSM, counter and shift registers stay in this module.

Test Plan:
- A=0x1234, B=0x4321, C_in=0, Run for 1 cycle -> Busy for 4 cycles, then Done=1 with Sum=0x5555, C_out=0, Overflow=0; Ready=1 on the next cycle.
- A=0xFFFF, B=0x0001, C_in=0 -> Sum=0x0000, C_out=1, Overflow=0. Separately, A=0x00FF, B=0x0000, C_in=1 -> Sum=0x0100, C_out=0.
- A=0x7FFF, B=0x0001 -> Sum=0x8000, C_out=0, Overflow=1. Separately, A=0x8000, B=0x8000 -> Sum=0x0000, C_out=1, Overflow=1.
- Accept 0x0001+0x0001, then pulse Run with A=0xAAAA, B=0x5555 during ADD and during DONE -> both ignored. Result is Sum=0x0002, and exactly one Done pulse.
- Run held high with operands changing after each Done -> one accept every 6 cycles (WIDTH=16); each Sum matches a reference add of the operands sampled at its own accept edge.
- Assert Reset_n=0 during the 3rd ADD cycle of 0xFFFF+0xFFFF -> immediately Sum=0, C_out=0, Overflow=0, Done=0. After release Ready=1, and 0x0F0F+0x0101 -> Sum=0x1010.
